// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin mux8 arbiter.
package mux8_arb_pkg;

  localparam int unsigned N_SRC = 8;
  localparam int unsigned SEL_W = 3;
  localparam int unsigned CNT_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  function automatic logic [N_SRC-1:0] onehot3(input logic [SEL_W-1:0] idx);
    onehot3 = N_SRC'(1) << idx;
  endfunction

endpackage

// File: rtl/mux8.sv
// Plain 8:1 bit multiplexer.
module mux8 (
  input  logic [7:0] i,
  input  logic [2:0] sel,
  output logic       y
);

  assign y = i[sel];

endmodule

// File: rtl/rr_pick8.sv
// Finds the first set candidate bit, searching upward from start and wrapping.
module rr_pick8
  import mux8_arb_pkg::*;
(
  input  logic [N_SRC-1:0] cand,
  input  logic [SEL_W-1:0] start,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = start;
    for (int k = 0; k < int'(N_SRC); k++) begin
      if (!found && cand[start + SEL_W'(k)]) begin
        found = 1'b1;
        idx   = start + SEL_W'(k);
      end
    end
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter owning the mux8 select, with a bounded hold per owner.
module mux8_rr_arbiter
  import mux8_arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] req,
  input  logic [N_SRC-1:0] i,
  output logic [N_SRC-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             y
);

  localparam logic [CNT_W-1:0] HOLD_TOP = CNT_W'(HOLD_MAX - 1);

  arb_state_t       state_q, state_d;
  logic [SEL_W-1:0] owner_q, owner_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_SRC-1:0] gnt_q, gnt_d;
  logic             busy_q, busy_d;

  logic [SEL_W-1:0] start_c;
  logic             rel_found_c, pre_found_c;
  logic [SEL_W-1:0] rel_idx_c, pre_idx_c;
  logic             mux_y_c;

  // In GRANT last equals owner, so last+1 is also the post-owner search start.
  assign start_c = last_q + SEL_W'(1);

  rr_pick8 u_pick_rel (
    .cand  (req),
    .start (start_c),
    .found (rel_found_c),
    .idx   (rel_idx_c)
  );

  rr_pick8 u_pick_pre (
    .cand  (req & ~onehot3(owner_q)),
    .start (start_c),
    .found (pre_found_c),
    .idx   (pre_idx_c)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (rel_found_c) begin
          state_d = GRANT;
          owner_d = rel_idx_c;
          last_d  = rel_idx_c;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (!req[owner_q]) begin
          if (rel_found_c) begin
            owner_d = rel_idx_c;
            last_d  = rel_idx_c;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (cnt_q == HOLD_TOP && pre_found_c) begin
          owner_d = pre_idx_c;
          last_d  = pre_idx_c;
          cnt_d   = '0;
        end else if (cnt_q != HOLD_TOP) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
    busy_d = (state_d == GRANT);
    gnt_d  = busy_d ? onehot3(owner_d) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= SEL_W'(N_SRC - 1);
      cnt_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
    end
  end

  mux8 u_mux8 (
    .i   (i),
    .sel (owner_q),
    .y   (mux_y_c)
  );

  assign gnt  = gnt_q;
  assign sel  = owner_q;
  assign busy = busy_q;
  assign y    = busy_q & mux_y_c;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Bench for mux8_rr_arbiter: directed scenarios plus random traffic on HOLD_MAX=4 and HOLD_MAX=1.
module tb_mux8_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] req = 8'h00;
  logic [7:0] i = 8'h00;
  logic [7:0] gnt0, gnt1;
  logic [2:0] sel0, sel1;
  logic       busy0, busy1, y0, y1;

  always #5 clk = ~clk;

  mux8_rr_arbiter #(.HOLD_MAX(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .i(i),
    .gnt(gnt0), .sel(sel0), .busy(busy0), .y(y0)
  );

  mux8_rr_arbiter #(.HOLD_MAX(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .i(i),
    .gnt(gnt1), .sel(sel1), .busy(busy1), .y(y1)
  );

  // Reference model: one entry per instance.
  int m_owner[2] = '{0, 0};
  int m_last[2]  = '{7, 7};
  int m_cnt[2]   = '{0, 0};
  bit m_busy[2]  = '{0, 0};
  int hmax[2]    = '{4, 1};

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  bit         lit_en = 0;
  bit         lit_y_en = 0;
  string      lit_name = "";
  logic [7:0] lit_gnt;
  logic [2:0] lit_sel;
  logic       lit_busy, lit_y;

  function automatic int rr_pick(input logic [7:0] c, input int start);
    for (int k = 0; k < 8; k++) begin
      int n;
      n = (start + k) % 8;
      if (c[n]) return n;
    end
    return -1;
  endfunction

  task automatic model_step(input int d, input logic [7:0] r);
    int p;
    logic [7:0] others;
    if (!m_busy[d]) begin
      p = rr_pick(r, m_last[d] + 1);
      if (p >= 0) begin
        m_busy[d] = 1; m_owner[d] = p; m_last[d] = p; m_cnt[d] = 0;
      end
    end else if (!r[m_owner[d]]) begin
      p = rr_pick(r, m_owner[d] + 1);
      if (p >= 0) begin
        m_owner[d] = p; m_last[d] = p; m_cnt[d] = 0;
      end else begin
        m_busy[d] = 0;
      end
    end else begin
      others = r & ~(8'(1) << m_owner[d]);
      if (m_cnt[d] == hmax[d] - 1 && others != 8'h00) begin
        p = rr_pick(others, m_owner[d] + 1);
        m_owner[d] = p; m_last[d] = p; m_cnt[d] = 0;
      end else if (m_cnt[d] < hmax[d] - 1) begin
        m_cnt[d] = m_cnt[d] + 1;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_owner[d] = 0; m_last[d] = 7; m_cnt[d] = 0; m_busy[d] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) model_step(d, req);
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Single compare process: model check every cycle, plus literal pins when armed.
  always @(negedge clk) begin
    logic [7:0] g;
    logic [2:0] s;
    logic       b, yy, ey;
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        g  = (d == 0) ? gnt0 : gnt1;
        s  = (d == 0) ? sel0 : sel1;
        b  = (d == 0) ? busy0 : busy1;
        yy = (d == 0) ? y0 : y1;
        ey = m_busy[d] ? i[m_owner[d]] : 1'b0;
        chk($sformatf("d%0d_gnt", d), 32'(g), m_busy[d] ? 32'(8'(1) << m_owner[d]) : 32'h0);
        chk($sformatf("d%0d_sel", d), 32'(s), 32'(m_owner[d]));
        chk($sformatf("d%0d_busy", d), 32'(b), 32'(m_busy[d]));
        chk($sformatf("d%0d_y", d), 32'(yy), 32'(ey));
      end
      if (lit_en) begin
        chk({lit_name, "_gnt"}, 32'(gnt0), 32'(lit_gnt));
        chk({lit_name, "_sel"}, 32'(sel0), 32'(lit_sel));
        chk({lit_name, "_busy"}, 32'(busy0), 32'(lit_busy));
        if (lit_y_en) chk({lit_name, "_y"}, 32'(y0), 32'(lit_y));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    lit_en = 0;
  endtask

  task automatic want(input string nm, input logic [7:0] g, input logic [2:0] s, input logic b);
    lit_name = nm; lit_gnt = g; lit_sel = s; lit_busy = b;
    lit_y_en = 0; lit_en = 1;
  endtask

  task automatic want_y(input logic v);
    lit_y = v; lit_y_en = 1;
  endtask

  task automatic do_reset();
    rst_n = 0; req = 8'h00;
    tick(); tick();
    rst_n = 1;
  endtask

  initial begin
    int r;
    #1;
    rst_n = 0;
    chk_en = 1;
    want("reset", 8'h00, 3'd0, 1'b0); want_y(1'b0);
    tick(); tick();
    rst_n = 1; req = 8'h81;
    tick();
    want("first", 8'h01, 3'd0, 1'b1);
    tick();

    // Full load: every owner holds exactly four cycles, in index order.
    do_reset();
    req = 8'hFF;
    for (int c = 0; c < 36; c++) begin
      tick();
      want("rot", 8'(1) << ((c / 4) % 8), 3'((c / 4) % 8), 1'b1);
    end
    tick();

    do_reset();
    req = 8'h08;
    tick(); want("zb_own", 8'h08, 3'd3, 1'b1);
    req = 8'h28;
    tick(); want("zb_hold", 8'h08, 3'd3, 1'b1);
    req = 8'h20;
    tick(); want("zb_hand", 8'h20, 3'd5, 1'b1);
    tick();

    do_reset();
    req = 8'h04;
    repeat (20) begin
      tick(); want("sole", 8'h04, 3'd2, 1'b1);
    end
    req = 8'h44;
    tick(); want("pre6", 8'h40, 3'd6, 1'b1);
    i = 8'h40; want_y(1'b1);
    tick(); want("data0", 8'h40, 3'd6, 1'b1);
    i = 8'hBF; want_y(1'b0);
    req = 8'h00;
    tick(); want("idle", 8'h00, 3'd6, 1'b0);
    i = 8'hFF; want_y(1'b0);
    tick();

    // Asynchronous reset pulse between edges while source 5 owns.
    do_reset();
    req = 8'h20;
    tick(); want("own5", 8'h20, 3'd5, 1'b1); want_y(1'b1);
    tick();
    #1 rst_n = 0;
    want("arst", 8'h00, 3'd0, 1'b0); want_y(1'b0);
    @(negedge clk);
    #1 rst_n = 1; req = 8'h21;
    tick(); want("after", 8'h01, 3'd0, 1'b1);
    tick();

    do_reset();
    repeat (3000) begin
      tick();
      r = $urandom_range(0, 9);
      if (r < 3) req = 8'($urandom);
      else if (r < 8) req = req ^ (8'(1) << $urandom_range(0, 7));
      else if (r == 8) req = 8'h00;
      else req = 8'(1) << $urandom_range(0, 7);
      i = 8'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        #1 rst_n = 0;
        @(negedge clk);
        #1 rst_n = 1;
      end
    end
    tick(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
